// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and types for the FIFO stream reader.
package fifo_stream_reader_pkg;

  localparam int DATA_WIDTH      = 8;
  localparam int CNT_WIDTH       = 16;
  // Cycles between an accepted read strobe and valid FIFO data.
  localparam int FIFO_RD_LATENCY = 1;

  // Output buffer fill level; encodings double as the numeric count.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry register buffer: push at the tail, pop from the head.
// Head data comes straight from a storage register, so the stream
// output never sees the FIFO data bus combinationally.
module stream_skid_buf2
  import fifo_stream_reader_pkg::*;
#(
  parameter int data_width = DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic [data_width-1:0] push_data,
  input  logic                  pop,
  input  logic                  clear,
  output logic [data_width-1:0] head_data,
  output occ_e                  occ
);

  logic [data_width-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;

  // Storage, pointers and fill level; clear drops everything buffered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      // NOTE: the two storage words are reset so the head reads 0 out of reset;
      // a large RAM would normally be left unreset.
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= OCC_EMPTY;
    end else if (clear) begin
      rd_ptr <= wr_ptr;
      occ    <= OCC_EMPTY;
    end else begin
      // NOTE: non-blocking assignments so every register here sees the
      // pre-edge values of the others, whatever the statement order.
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   occ <= (occ == OCC_EMPTY) ? OCC_ONE : OCC_TWO;
        2'b01:   occ <= (occ == OCC_TWO) ? OCC_ONE : OCC_EMPTY;
        default: occ <= occ;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side unloader for the synchronous FIFO: issues read strobes on
// credit, captures the returned word one cycle later into a 2-entry
// buffer and presents it on a valid/ready stream.
// Optional build macro FIFO_STREAM_READER_FLUSH_EN adds a flush input.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int cnt_width  = CNT_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
`ifdef FIFO_STREAM_READER_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  fifo_empty,
  input  logic [data_width-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [data_width-1:0] m_data,
  output logic [cnt_width-1:0]  xfer_count
);

  occ_e       occ;
  logic       inflight;
  logic       pop;
  logic       capture;
  logic       flush_now;
  logic [2:0] committed;

  assign m_valid = (occ != OCC_EMPTY);
  assign pop     = m_valid & m_ready;

  // Words already owned by this block: buffered plus the one on the bus.
  assign committed = {1'b0, occ} + {2'b00, inflight};

`ifdef FIFO_STREAM_READER_FLUSH_EN
  logic discard;

  assign flush_now = flush;
  assign capture   = inflight & ~discard;

  // Marks the cycle after a flush so a returning word is dropped.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) discard <= 1'b0;
    else      discard <= flush;
  end
`else
  assign flush_now = 1'b0;
  assign capture   = inflight;
`endif

  // Read only while a slot is guaranteed once the current pop is counted.
  always_comb begin
    // NOTE: default first so every path assigns the output and no latch forms.
    fifo_rd_en = 1'b0;
    if (RST && !fifo_empty && !flush_now && (committed < 3'd2 + {2'b00, pop}))
      fifo_rd_en = 1'b1;
  end

  // In-flight marker and transfer counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      inflight   <= 1'b0;
      xfer_count <= '0;
    end else begin
      inflight   <= fifo_rd_en;
      xfer_count <= xfer_count + {{(cnt_width-1){1'b0}}, pop};
    end
  end

  stream_skid_buf2 #(
    .data_width (data_width)
  ) u_buf (
    .CLK       (CLK),
    .RST       (RST),
    .push      (capture),
    .push_data (fifo_data),
    .pop       (pop),
    .clear     (flush_now),
    .head_data (m_data),
    .occ       (occ)
  );

endmodule
